// File: rtl/osd_spi_ctrl.sv
// osd_spi_ctrl: round-robin SPI master that serialises OSD enable and line-write transactions
module osd_spi_ctrl #(
  parameter int SCK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk_sys_i,
  input  logic       reset_i,
  input  logic       a_req_i,
  input  logic       a_kind_i,
  input  logic       a_en_i,
  input  logic [2:0] a_line_i,
  input  logic [7:0] a_len_i,
  output logic       a_rd_o,
  output logic [7:0] a_addr_o,
  input  logic [7:0] a_data_i,
  output logic       a_done_o,
  input  logic       b_req_i,
  input  logic       b_kind_i,
  input  logic       b_en_i,
  input  logic [2:0] b_line_i,
  input  logic [7:0] b_len_i,
  output logic       b_rd_o,
  output logic [7:0] b_addr_o,
  input  logic [7:0] b_data_i,
  output logic       b_done_o,
  output logic       busy_o,
  output logic       spi_sck_o,
  output logic       spi_ss3_o,
  output logic       spi_di_o
);
  typedef enum logic [2:0] {IDLE, GRANT, SETUP, SHIFT, FETCH, HOLD, GAP} state_t;
  localparam logic [15:0] HALF  = 16'(SCK_DIV - 1);
  localparam logic [15:0] HOLDN = 16'(2 * SCK_DIV - 1);
  localparam logic [15:0] GAPN  = 16'(GAP_CYCLES - 1);
  state_t      state_q;
  logic        nxt_q, sel_q, kind_q, en_q, dat_q;
  logic [2:0]  line_q, bit_q;
  logic [7:0]  len_q, addr_q, sh_q;
  logic [15:0] cnt_q;
  logic        sck_q, ss3_q, di_q, busy_q, a_rd_q, b_rd_q, a_done_q, b_done_q;
  logic        win, more, half;
  logic [7:0]  cmd, rdata;
  always_comb begin
    win   = (a_req_i && b_req_i) ? nxt_q : b_req_i;
    cmd   = kind_q ? {5'b00100, line_q} : {7'b0100000, en_q};
    rdata = sel_q ? b_data_i : a_data_i;
    more  = kind_q && (!dat_q || addr_q != len_q);
    half  = cnt_q == HALF;
  end
  assign a_rd_o    = a_rd_q;
  assign b_rd_o    = b_rd_q;
  assign a_addr_o  = addr_q;
  assign b_addr_o  = addr_q;
  assign a_done_o  = a_done_q;
  assign b_done_o  = b_done_q;
  assign busy_o    = busy_q;
  assign spi_sck_o = sck_q;
  assign spi_ss3_o = ss3_q;
  assign spi_di_o  = di_q;
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      nxt_q    <= 1'b0;
      sel_q    <= 1'b0;
      kind_q   <= 1'b0;
      en_q     <= 1'b0;
      dat_q    <= 1'b0;
      line_q   <= '0;
      bit_q    <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      sh_q     <= '0;
      cnt_q    <= '0;
      sck_q    <= 1'b0;
      ss3_q    <= 1'b1;
      di_q     <= 1'b0;
      busy_q   <= 1'b0;
      a_rd_q   <= 1'b0;
      b_rd_q   <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
    end else begin
      a_rd_q   <= 1'b0;
      b_rd_q   <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      cnt_q    <= cnt_q + 16'd1;
      case (state_q)
        IDLE: if (a_req_i || b_req_i) begin
          state_q <= GRANT;
          busy_q  <= 1'b1;
          sel_q   <= win;
          nxt_q   <= ~win;
          kind_q  <= win ? b_kind_i : a_kind_i;
          en_q    <= win ? b_en_i : a_en_i;
          line_q  <= win ? b_line_i : a_line_i;
          len_q   <= win ? b_len_i : a_len_i;
        end
        GRANT: begin
          state_q <= SETUP;
          ss3_q   <= 1'b0;
          sh_q    <= cmd;
          di_q    <= cmd[7];
          bit_q   <= '0;
          dat_q   <= 1'b0;
          addr_q  <= '0;
          cnt_q   <= '0;
        end
        SETUP: if (half) begin
          state_q <= SHIFT;
          sck_q   <= 1'b1;
          cnt_q   <= '0;
        end
        // DI only moves on the falling edge, so it is settled a full half-period before each rise
        SHIFT: if (half) begin
          cnt_q <= '0;
          if (!sck_q) sck_q <= 1'b1;
          else begin
            sck_q <= 1'b0;
            if (bit_q != 3'd7) begin
              bit_q <= bit_q + 3'd1;
              sh_q  <= {sh_q[6:0], 1'b0};
              di_q  <= sh_q[6];
            end else if (more) begin
              state_q <= FETCH;
              a_rd_q  <= ~sel_q;
              b_rd_q  <= sel_q;
              addr_q  <= dat_q ? addr_q + 8'd1 : 8'd0;
              dat_q   <= 1'b1;
            end else state_q <= HOLD;
          end
        end
        // cycle 0 issues the read, the byte arrives for capture at the end of cycle 1
        FETCH: if (cnt_q[0]) begin
          state_q <= SHIFT;
          sh_q    <= rdata;
          di_q    <= rdata[7];
          bit_q   <= '0;
          cnt_q   <= '0;
        end
        HOLD: if (cnt_q == HOLDN) begin
          state_q  <= GAP;
          ss3_q    <= 1'b1;
          di_q     <= 1'b0;
          a_done_q <= ~sel_q;
          b_done_q <= sel_q;
          cnt_q    <= '0;
        end
        GAP: if (cnt_q == GAPN) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
